// File: rtl/alu_pkg.sv
// Shared ALU constants, subtractor FSM state codes and the condition-flag bundle
// consumed by the compare stage.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_DIGIT = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  typedef struct packed {
    logic zero;
    logic neg;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/sub_flag_gen_if.sv
// Request/result handshake bundle between the issuing stage and sub_flag_gen.
interface sub_flag_gen_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sign;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport master (
    output in_valid, a, b, sign, out_ready,
    input  in_ready, out_valid, diff, zero, neg, ovf
  );

  modport slave (
    input  in_valid, a, b, sign, out_ready,
    output in_ready, out_valid, diff, zero, neg, ovf
  );
endinterface

// File: rtl/digit_sub.sv
// Combinational DIGIT-bit adder; subtraction is formed by feeding the inverted
// subtrahend and a carry-in of 1 on the first slice.
module digit_sub #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] nb,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  always_comb begin
    {cout, s} = {1'b0, a} + {1'b0, nb} + {{DIGIT{1'b0}}, cin};
  end

endmodule

// File: rtl/sub_flag_gen.sv
// Digit-serial subtractor: computes a - b one DIGIT slice per clock and registers
// the difference together with the zero/neg/ovf flags.
module sub_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DIGIT = ALU_DIGIT
) (
  input logic           clk,
  input logic           reset,
  sub_flag_gen_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] nb_sh;
  logic [WIDTH-1:0] diff_sh;
  logic             carry;
  logic             zero_acc;
  logic             sign_q;
  logic             a_msb;
  logic             b_msb;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] diff_q;
  flags_t           flags_q;

  logic [DIGIT-1:0] s;
  logic             c_out;
  logic [WIDTH-1:0] diff_next;
  logic             last_slice;
  flags_t           flags_next;

  digit_sub #(
    .DIGIT(DIGIT)
  ) u_digit_sub (
    .a   (a_sh[DIGIT-1:0]),
    .nb  (nb_sh[DIGIT-1:0]),
    .cin (carry),
    .s   (s),
    .cout(c_out)
  );

  always_comb begin
    // Result slices enter from the MSB end so the LSB slice lands at bit 0 last.
    diff_next       = {s, diff_sh[WIDTH-1:DIGIT]};
    last_slice      = (cnt == CW'(N - 1));
    flags_next.zero = zero_acc & (s == '0);
    flags_next.ovf  = (a_msb != b_msb) & (s[DIGIT-1] != a_msb);
    // Unsigned less-than is the borrow out of the top slice.
    flags_next.neg  = sign_q ? (s[DIGIT-1] ^ flags_next.ovf) : ~c_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a_sh     <= '0;
      nb_sh    <= '0;
      diff_sh  <= '0;
      carry    <= 1'b0;
      zero_acc <= 1'b0;
      sign_q   <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      flags_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh     <= bus.a;
            nb_sh    <= ~bus.b;
            sign_q   <= bus.sign;
            a_msb    <= bus.a[WIDTH-1];
            b_msb    <= bus.b[WIDTH-1];
            carry    <= 1'b1;
            cnt      <= '0;
            zero_acc <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh     <= a_sh >> DIGIT;
          nb_sh    <= nb_sh >> DIGIT;
          diff_sh  <= diff_next;
          carry    <= c_out;
          zero_acc <= zero_acc & (s == '0);
          cnt      <= cnt + 1'b1;
          if (last_slice) begin
            diff_q  <= diff_next;
            flags_q <= flags_next;
            state   <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) & ~reset;
  assign bus.out_valid = (state == DONE);
  assign bus.diff      = diff_q;
  assign bus.zero      = flags_q.zero;
  assign bus.neg       = flags_q.neg;
  assign bus.ovf       = flags_q.ovf;

endmodule

// File: doc/sub_flag_gen.md
# sub_flag_gen

Multi-cycle subtractor that computes A − B a DIGIT-wide slice per clock and produces the `zero`, `neg` and `ovf` condition flags. The compare stage of the ALU consumes these flags to form EQ/NEQ/LT/LEZ/GEZ/GTZ. It is the flag-producing end of that interface and trades latency for area on the compare/branch path. It also returns the 32-bit difference.

## Interface

**Parameters**
- `WIDTH`, default 32: operand width. Must be a multiple of `DIGIT`.
- `DIGIT`, default 4: bits processed per cycle. N = WIDTH/DIGIT, which is 8 by default.

**Ports** (clock and reset first)
- `clk`, in, 1: the single clock. All state changes on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `in_valid`, in, 1: request valid.
- `in_ready`, out, 1: block can accept a request. High only in IDLE and while `reset` is low.
- `a`, in, WIDTH: minuend.
- `b`, in, WIDTH: subtrahend.
- `sign`, in, 1: 1 = signed compare, 0 = unsigned.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts the result.
- `diff`, out, WIDTH: a − b, modulo 2^WIDTH.
- `zero`, out, 1: diff == 0.
- `neg`, out, 1: a < b under the `sign` mode.
- `ovf`, out, 1: signed two's-complement overflow of a − b. Computed regardless of `sign`.

## Operation

**FSM states:** IDLE, RUN, DONE.

**IDLE**
- `in_ready` = 1.
- On `in_valid & in_ready`, latch `a`, `~b`, `sign` and the operand MSBs.
- Set carry = 1, cnt = 0, zero_acc = 1, then go to RUN.

**RUN**
- At each edge, compute {c_out, s} = a_sh[DIGIT-1:0] + nb_sh[DIGIT-1:0] + carry.
- Shift `s` into diff_sh from the MSB end.
- Shift both operand registers right by DIGIT.
- Update carry = c_out, zero_acc &= (s == 0), cnt += 1.
- At the edge where cnt == N−1 (the last slice), register the flags and go to DONE:
  - `diff` = final diff_sh.
  - `zero` = zero_acc & (s == 0).
  - `ovf` = (a_msb != b_msb) & (diff_msb != a_msb).
  - `neg` = sign ? (diff_msb ^ ovf) : ~c_out. The unsigned case is the borrow.
- `in_valid` is ignored.

**DONE**
- `out_valid` = 1.
- `diff`, `zero`, `neg`, `ovf` are held stable while `out_ready` = 0.
- On `out_ready`, go to IDLE.
- `in_ready` = 0. There is no overlap of request and result.

**Width rules**
- Carry is a 1-bit register.
- cnt is $clog2(N) bits and never wraps inside a request, because it is cleared on accept.

**Result outputs**
- Registered only. After a handshake they keep their last value until the next DONE.
- They are meaningful only while `out_valid` = 1.

## Timing

**Reset** (any state, including mid-RUN or DONE)
- Next state is IDLE. The in-flight request is discarded and no `out_valid` is produced for it.
- `out_valid` = 0, `diff` = 0, `zero` = 0, `neg` = 0, `ovf` = 0.
- `in_ready` = 0 while `reset` is high and 1 in the first cycle after it drops.

**Latency**
- Request accepted at edge E.
- RUN processes slice i at edge E+1+i.
- `out_valid` rises after edge E+N, which is 8 cycles by default.

**Throughput**
- Result consumed at edge E+N+1 at the earliest.
- IDLE holds from then on. The next accept is at edge E+N+2.
- Minimum period is N+2 cycles.

**Simultaneous events**
- `in_valid` during RUN or DONE is not accepted. The upstream stage must hold it.
- `out_ready` outside DONE has no effect.

## Structure

- **Package `alu_pkg`:**
  - state enum {IDLE, RUN, DONE};
  - `ALU_WIDTH` = 32 and `ALU_DIGIT` = 4 default constants;
  - flag-bundle typedef {zero, neg, ovf}, shared with the compare stage.
- **One sub-module, `digit_sub`:** combinational DIGIT-bit adder taking (a, nb, cin) and returning (s, cout), instantiated once. The FSM, shift registers and flag logic live in `sub_flag_gen`.

## Test plan

Unless stated, `out_ready` = 1 and all scenarios use defaults. "Signed" means `sign` = 1.

1. **Equal operands.** a=5, b=5, signed, accepted at edge 0 → `out_valid` after edge 8 with diff=0x00000000, zero=1, neg=0, ovf=0. IDLE after edge 9.
2. **Small less-than.** a=3, b=7, signed → diff=0xFFFFFFFC, zero=0, neg=1, ovf=0. Repeat unsigned → neg=1 (borrow).
3. **Signed overflow.** a=0x80000000, b=1, signed → diff=0x7FFFFFFF, ovf=1, neg=1. Unsigned → neg=0, ovf=1.
4. **Sign-dependent `neg`.** a=0xFFFFFFFF, b=1: unsigned → neg=0, diff=0xFFFFFFFE; signed → neg=1, ovf=0.
5. **Backpressure.** Hold `out_ready`=0 for 5 cycles in DONE while pulsing `in_valid` → outputs stable, `in_ready`=0, no second accept. Raise `out_ready` → IDLE next cycle, then the pending request is accepted.
6. **Reset mid-operation.** Assert `reset` for one cycle during RUN, after slice 4 → `out_valid` never rises for that request. `in_ready`=1 in the cycle after reset drops. A fresh request a=9, b=2 then gives diff=7 after 8 cycles.
